// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register write-back block: bus widths,
// enable levels, the default buffer depth and the buffer entry layout.
package reg_wb_pkg;

   localparam int RegAddrW = 5;
   localparam int RegDataW = 32;

   // Register address and data buses.
   typedef logic [RegAddrW-1:0] reg_addr_t;
   typedef logic [RegDataW-1:0] reg_data_t;

   // Active levels used throughout the write-back path.
   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic RstEnable    = 1'b1;

   // Number of multiply/divide results that can wait for a write slot.
   localparam int WbDepthDefault = 2;

   // One buffered multiply/divide result. A dead entry still occupies its
   // slot until popped, but it never reaches the register file.
   typedef struct packed {
      logic      live;
      reg_addr_t addr;
      reg_data_t data;
   } wb_entry_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// wb_fifo: small FIFO of pending multiply/divide results with wrap-around
// pointers, kill-by-address (WAW squash) and a live-address query port.
module wb_fifo
   import reg_wb_pkg::*;
#(
   parameter int DEPTH = WbDepthDefault
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  reg_addr_t push_addr,
   input  reg_data_t push_data,
   input  logic      push_dead,
   input  logic      pop,
   input  logic      kill,
   input  reg_addr_t kill_addr,
   input  reg_addr_t query_addr,
   output wb_entry_t head,
   output logic      hit,
   output logic [2:0] count
);

   // DEPTH is 2 or 4, so the pointers wrap naturally at their width.
   localparam int PW = (DEPTH > 2) ? 2 : 1;

   wb_entry_t         mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [2:0]        cnt;

   // Storage, pointers and count. Kill is applied to existing entries first;
   // a same-cycle push carries its own dead flag, and popped slots are
   // marked dead so stale contents never answer a query.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i].live <= 1'b0;
            mem[i].addr <= '0;
            mem[i].data <= '0;
         end
      end else begin
         if (kill && (kill_addr != '0)) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (mem[i].addr == kill_addr) mem[i].live <= 1'b0;
            end
         end
         if (pop) begin
            mem[rd_ptr].live <= 1'b0;
            rd_ptr           <= rd_ptr + PW'(1);
         end
         if (push) begin
            mem[wr_ptr].live <= ~push_dead;
            mem[wr_ptr].addr <= push_addr;
            mem[wr_ptr].data <= push_data;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 3'd1;
            2'b01:   cnt <= cnt - 3'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Hazard query: any live entry whose address matches a non-zero query.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i].live && (mem[i].addr == query_addr) && (query_addr != '0)) hit = 1'b1;
      end
   end

   assign head  = mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/reg_wb.sv
// reg_wb: register-file write-back arbiter. One write slot per cycle; the
// single-cycle ALU always wins, buffered multiply/divide results drain when
// the ALU is idle, and an empty buffer lets a new result bypass directly.
//
// Handshake: a multiply/divide result transfers in any cycle where
// md_valid_i and md_ready_o are both 1. md_ready_o depends only on reset and
// buffer occupancy, never on md_valid_i; the producer holds its result
// stable until it transfers.
module reg_wb
   import reg_wb_pkg::*;
#(
   parameter int WB_DEPTH = WbDepthDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_waddr_i,
   input  logic [31:0] alu_wdata_i,
   input  logic        md_valid_i,
   input  logic [4:0]  md_waddr_i,
   input  logic [31:0] md_wdata_i,
   output logic        md_ready_o,
   output logic        we_o,
   output logic [4:0]  waddr_o,
   output logic [31:0] wdata_o,
   input  logic [4:0]  chk_addr_i,
   output logic        chk_hit_o,
   output logic [2:0]  occ_o
);

   wb_entry_t  head;
   logic       fifo_hit;
   logic [2:0] fifo_count;
   logic       xfer;
   logic       push;
   logic       push_dead;
   logic       pop;
   logic       kill;
   logic       sel_live;
   reg_addr_t  sel_addr;
   reg_data_t  sel_data;
   logic       sel_we;

   assign md_ready_o = (rst != RstEnable) && (fifo_count < 3'(WB_DEPTH));
   assign xfer       = md_valid_i && md_ready_o;
   assign kill       = (rst != RstEnable) && alu_valid_i && (alu_waddr_i != '0);

   // Slot arbitration: ALU, then buffer head, then direct bypass.
   always_comb begin
      sel_live  = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      push      = 1'b0;
      push_dead = 1'b0;
      pop       = 1'b0;
      if (rst != RstEnable) begin
         if (alu_valid_i) begin
            sel_live  = 1'b1;
            sel_addr  = alu_waddr_i;
            sel_data  = alu_wdata_i;
            push      = xfer;
            push_dead = (alu_waddr_i != '0) && (md_waddr_i == alu_waddr_i);
         end else if (fifo_count != '0) begin
            pop      = 1'b1;
            sel_live = head.live;
            sel_addr = head.addr;
            sel_data = head.data;
            push     = xfer;
         end else if (xfer) begin
            sel_live = 1'b1;
            sel_addr = md_waddr_i;
            sel_data = md_wdata_i;
         end
      end
   end

   // Address 0 and dead entries consume their slot without writing.
   assign sel_we = sel_live && (sel_addr != '0);

   // Registered write port; address and data are zeroed when not writing.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         we_o    <= WriteDisable;
         waddr_o <= '0;
         wdata_o <= '0;
      end else begin
         we_o    <= sel_we ? WriteEnable : WriteDisable;
         waddr_o <= sel_we ? sel_addr : '0;
         wdata_o <= sel_we ? sel_data : '0;
      end
   end

   wb_fifo #(
      .DEPTH (WB_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_addr  (md_waddr_i),
      .push_data  (md_wdata_i),
      .push_dead  (push_dead),
      .pop        (pop),
      .kill       (kill),
      .kill_addr  (alu_waddr_i),
      .query_addr (chk_addr_i),
      .head       (head),
      .hit        (fifo_hit),
      .count      (fifo_count)
   );

   assign chk_hit_o = (rst != RstEnable) && fifo_hit;
   assign occ_o     = fifo_count;

endmodule

// File: tb/tb_reg_wb.sv
// Bench for reg_wb: directed write-back scenarios. Expected register writes
// are queued as stimulus is issued; a monitor compares every cycle's write
// port against the queue head.
module tb_reg_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid_i;
   logic [4:0]  alu_waddr_i;
   logic [31:0] alu_wdata_i;
   logic        md_valid_i;
   logic [4:0]  md_waddr_i;
   logic [31:0] md_wdata_i;
   logic        md_ready_o;
   logic        we_o;
   logic [4:0]  waddr_o;
   logic [31:0] wdata_o;
   logic [4:0]  chk_addr_i;
   logic        chk_hit_o;
   logic [2:0]  occ_o;

   int          tests = 0;
   int          fails = 0;
   logic [36:0] exp_q[$];
   logic        mon_en = 1'b0;

   // Clock and DUT
   always #5 clk = ~clk;

   reg_wb #(
      .WB_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid_i (alu_valid_i),
      .alu_waddr_i (alu_waddr_i),
      .alu_wdata_i (alu_wdata_i),
      .md_valid_i  (md_valid_i),
      .md_waddr_i  (md_waddr_i),
      .md_wdata_i  (md_wdata_i),
      .md_ready_o  (md_ready_o),
      .we_o        (we_o),
      .waddr_o     (waddr_o),
      .wdata_o     (wdata_o),
      .chk_addr_i  (chk_addr_i),
      .chk_hit_o   (chk_hit_o),
      .occ_o       (occ_o)
   );

   task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // Apply one cycle of inputs at a falling edge and wait for the next one.
   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
      alu_valid_i = av;
      alu_waddr_i = aa;
      alu_wdata_i = ad;
      md_valid_i  = mv;
      md_waddr_i  = ma;
      md_wdata_i  = md;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   // Monitor: every write must match the next expected one; idle cycles
   // must present a zeroed address and data.
   always @(negedge clk) begin
      if (mon_en) begin
         if (we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got x%0d=0x%0h, want no write", waddr_o, wdata_o);
            end else begin
               check("write", {waddr_o, wdata_o}, exp_q.pop_front());
            end
         end else begin
            check("idle_port", {we_o, waddr_o, wdata_o}, 37'h0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      chk_addr_i = 5'd0;
      alu_valid_i = 1'b0; alu_waddr_i = '0; alu_wdata_i = '0;
      md_valid_i = 1'b1; md_waddr_i = 5'd9; md_wdata_i = 32'h99;
      @(negedge clk);
      @(negedge clk);
      chk_addr_i = 5'd9;
      #1;
      check("reset_we", we_o, 0);
      check("reset_waddr", waddr_o, 0);
      check("reset_wdata", wdata_o, 0);
      check("reset_occ", occ_o, 0);
      check("reset_ready", md_ready_o, 0);
      check("reset_hit", chk_hit_o, 0);
      rst = 1'b0;
      md_valid_i = 1'b0;
      chk_addr_i = 5'd0;
      #1;
      check("ready_after_reset", md_ready_o, 1);
      @(negedge clk);
      mon_en = 1'b1;

      // md x5 with idle ALU bypasses the buffer
      expect_wr(5'd5, 32'h11);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11);
      check("bypass_occ", occ_o, 0);
      idle();

      // ALU and md in the same cycle: ALU first, md next
      expect_wr(5'd3, 32'hA);
      expect_wr(5'd4, 32'hB);
      drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
      check("same_cycle_occ1", occ_o, 1);
      idle();
      check("same_cycle_occ0", occ_o, 0);
      idle();

      // Four ALU cycles against three md results
      for (int i = 0; i < 4; i++) expect_wr(5'(10 + i), 32'h100 + i);
      for (int i = 0; i < 3; i++) expect_wr(5'(20 + i), 32'h200 + i);
      drive(1'b1, 5'd10, 32'h100, 1'b1, 5'd20, 32'h200);
      check("burst_occ_a", occ_o, 1);
      drive(1'b1, 5'd11, 32'h101, 1'b1, 5'd21, 32'h201);
      check("burst_occ_b", occ_o, 2);
      check("burst_full_ready", md_ready_o, 0);
      drive(1'b1, 5'd12, 32'h102, 1'b1, 5'd22, 32'h202);
      check("burst_occ_c", occ_o, 2);
      drive(1'b1, 5'd13, 32'h103, 1'b1, 5'd22, 32'h202);
      check("burst_occ_d", occ_o, 2);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'h202);
      check("burst_occ_e", occ_o, 1);
      check("burst_ready_again", md_ready_o, 1);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'h202);
      check("burst_occ_f", occ_o, 1);
      idle();
      check("burst_drained", occ_o, 0);
      idle();

      // WAW kill of a buffered x7
      expect_wr(5'd8, 32'h80);
      drive(1'b1, 5'd8, 32'h80, 1'b1, 5'd7, 32'h1);
      chk_addr_i = 5'd7;
      #1;
      check("hit_before_kill", chk_hit_o, 1);
      chk_addr_i = 5'd0;
      #1;
      check("hit_addr0", chk_hit_o, 0);
      chk_addr_i = 5'd7;
      expect_wr(5'd7, 32'h2);
      drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'h0);
      #1;
      check("hit_after_kill", chk_hit_o, 0);
      check("dead_occ", occ_o, 1);
      idle();
      check("dead_popped", occ_o, 0);

      // Same-cycle enqueue to the ALU's address goes in dead
      expect_wr(5'd9, 32'h90);
      drive(1'b1, 5'd9, 32'h90, 1'b1, 5'd9, 32'h91);
      chk_addr_i = 5'd9;
      #1;
      check("dead_enq_hit", chk_hit_o, 0);
      check("dead_enq_occ", occ_o, 1);
      idle();
      check("dead_enq_popped", occ_o, 0);

      // Buffered x0 entry pops without writing
      expect_wr(5'd6, 32'h60);
      drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd0, 32'h5);
      check("x0_buffered_occ", occ_o, 1);
      idle();
      check("x0_popped", occ_o, 0);

      // md x0 bypass and ALU x0: no writes, nothing retained
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF);
      check("x0_bypass_occ", occ_o, 0);
      drive(1'b1, 5'd0, 32'h33, 1'b0, 5'd0, 32'h0);
      idle();

      // Reset with two buffered entries discards them
      expect_wr(5'd1, 32'hA1);
      expect_wr(5'd3, 32'hA3);
      drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
      drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hB4);
      check("pre_reset_occ", occ_o, 2);
      chk_addr_i = 5'd2;
      #1;
      check("pre_reset_hit", chk_hit_o, 1);
      rst = 1'b1;
      alu_valid_i = 1'b0;
      md_valid_i = 1'b1; md_waddr_i = 5'd12; md_wdata_i = 32'hC;
      #1;
      check("mid_reset_ready", md_ready_o, 0);
      check("mid_reset_hit", chk_hit_o, 0);
      @(negedge clk);
      check("mid_reset_we", we_o, 0);
      check("mid_reset_occ", occ_o, 0);
      rst = 1'b0;
      md_valid_i = 1'b0;
      #1;
      check("post_reset_ready", md_ready_o, 1);
      check("post_reset_hit", chk_hit_o, 0);
      repeat (3) idle();
      check("post_reset_occ", occ_o, 0);

      check("queue_empty", exp_q.size(), 0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_wb.md
REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 Parameter WB_DEPTH, default 2, meaning the number of entries in the multiply/divide result buffer (legal values: 2 or 4).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 alu_valid_i  input  1  single-cycle ALU result present this cycle; it is never stalled.
REQ-005 alu_waddr_i  input  5  ALU destination register.
REQ-006 alu_wdata_i  input  32  ALU result.
REQ-007 md_valid_i  input  1  multiply/divide result offered.
REQ-008 md_waddr_i  input  5  multiply/divide destination register.
REQ-009 md_wdata_i  input  32  multiply/divide result.
REQ-010 md_ready_o  output  1  buffer can accept a multiply/divide result; combinational from occupancy.
REQ-011 we_o  output  1  register-file write enable (registered).
REQ-012 waddr_o  output  5  register-file write address (registered).
REQ-013 wdata_o  output  32  register-file write data (registered).
REQ-014 chk_addr_i  input  5  decode hazard-query address.
REQ-015 chk_hit_o  output  1  a live buffered entry targets chk_addr_i; combinational.
REQ-016 occ_o  output  3  current buffer occupancy.

Function
REQ-017 A multiply/divide transfer SHALL occur in a cycle when md_valid_i=1 and md_ready_o=1; md_ready_o SHALL equal (occupancy < WB_DEPTH).
REQ-018 The block SHALL perform at most one register write per cycle, with a latency of 1: a source selected in cycle N SHALL drive we_o/waddr_o/wdata_o in cycle N+1.
REQ-019 Write-slot priority SHALL be: ALU result first, then the buffer head, then a direct multiply/divide transfer (the last only when occupancy=0).
REQ-020 When alu_valid_i=1 and a multiply/divide transfer occurs in the same cycle, the ALU result SHALL be written and the multiply/divide result SHALL be enqueued.
REQ-021 When alu_valid_i=0 and occupancy>0, the head entry SHALL be popped and written; a same-cycle transfer SHALL be enqueued, leaving occupancy unchanged.
REQ-022 When alu_valid_i=0, occupancy=0 and a transfer occurs, the result SHALL bypass the buffer.
REQ-023 The buffer SHALL be FIFO-ordered, with wrap-around read and write pointers and a count ranging over 0..WB_DEPTH.
REQ-024 Kill rule (WAW): when alu_valid_i=1 and alu_waddr_i != 0, every buffered entry with the same address SHALL be marked dead. A same-cycle enqueued entry with the same address SHALL also be enqueued dead.
REQ-025 A dead head entry SHALL be popped in its slot with we_o=0.
REQ-026 Any selected write whose address is 0 SHALL produce we_o=0 and SHALL still consume its slot or pop its entry.
REQ-027 When we_o=0, waddr_o and wdata_o SHALL be 0.
REQ-028 chk_hit_o SHALL be 1 if and only if chk_addr_i != 0 and a live entry with that address exists in the buffer; in-flight inputs SHALL NOT be included.
REQ-029 Dead entries SHALL count toward occupancy and md_ready_o until popped.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL set we_o=0, waddr_o=0, wdata_o=0, occupancy=0, both pointers to 0, and all entries to dead.
REQ-031 While rst=1, md_ready_o SHALL be 0, no transfer SHALL be accepted, and chk_hit_o SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries without issuing any write.

Structure
REQ-033 RegAddrBus, RegBus, WriteEnable, RstEnable and the new constant WbDepthDefault=2 SHALL live in the shared defines include.
REQ-034 The buffer SHALL be a sub-module wb_fifo (push, pop, kill-by-address, address query, count); reg_wb SHALL contain slot arbitration and the output register.

Verification
REQ-035 Scenario: md x5=0x11 with an idle ALU -> cycle+1: we_o=1, waddr_o=5, wdata_o=0x11; occ_o stays 0.
REQ-036 Scenario: ALU x3=0xA and md x4=0xB in the same cycle -> cycle+1 writes x3=0xA; cycle+2 writes x4=0xB; occ_o goes 1 then 0.
REQ-037 Scenario: ALU valid for 4 cycles while md offers 3 results -> md_ready_o drops after 2 accepts; the buffered results drain in order once the ALU idles; occ_o returns to 0.
REQ-038 Scenario: md x7=0x1 buffered, then ALU x7=0x2 -> the x7=0x2 write occurs; the buffered x7 pop produces we_o=0; a chk_addr_i=7 query returns hit=1 before the kill and 0 after.
REQ-039 Scenario: md x0=0xFF with an idle ALU -> we_o=0 in the next cycle; no entry is retained.
REQ-040 Scenario: occupancy=2, then rst=1 for one cycle -> we_o=0, occ_o=0, md_ready_o=0 during reset; md_ready_o=1 after reset; no stale write is ever issued.
